// File: rtl/router_out_pkt_reader.sv
// router_out_pkt_reader: drain-side controller for one router output FIFO.
// Pops header/payload/parity bytes, streams them with sop/eop marks, checks
// parity, and requests a FIFO soft reset when the destination stalls too long.
// Optional feature macro: ROUTER_OUT_PARITY_CHECK_EN (parity accumulator and
// comparison); when undefined, parity_err is tied low.
module router_out_pkt_reader #(
    parameter int TIMEOUT = 30,
    parameter int TO_W    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       empty,
    input  logic [7:0] data_out,
    input  logic       rx_ready,
    output logic       read_enb,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    output logic       pkt_sop,
    output logic       pkt_eop,
    output logic [5:0] pkt_len,
    output logic       pkt_done,
    output logic       parity_err,
    output logic       soft_reset_req,
    output logic       busy
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_valid;
    logic [6:0]      r_remaining;
    logic [6:0]      r_to_read;
    logic [5:0]      r_len;
    logic [TO_W-1:0] r_to_cnt;
    logic [6:0]      w_len_p1;
    logic            w_last;
    logic            w_stall;
    logic            w_timeout;

    assign w_len_p1       = {1'b0, data_out[7:2]} + 7'd1;
    assign w_last         = r_valid & (r_remaining == 7'd1);
    assign w_stall        = ~empty & ~rx_ready & ((r_state == S_IDLE) | (r_state == S_BODY));
    assign w_timeout      = w_stall & (r_to_cnt == TO_W'(TIMEOUT - 1));

    assign pkt_data       = data_out;
    assign pkt_valid      = r_valid;
    assign pkt_len        = r_len;
    assign soft_reset_req = w_timeout;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; a timeout abandons the packet without pkt_done
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_timeout)     w_next = S_IDLE;
                else if (read_enb) w_next = S_HDR;
            end
            S_HDR:  w_next = S_BODY;
            S_BODY: begin
                if (w_timeout)   w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode; read_enb is held low during reset so no byte is popped then
    always_comb begin
        read_enb = 1'b0;
        pkt_sop  = 1'b0;
        pkt_eop  = 1'b0;
        pkt_done = 1'b0;
        busy     = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: read_enb = ~empty & rx_ready & ~reset;
            S_HDR:  pkt_sop  = 1'b1;
            S_BODY: begin
                read_enb = ~empty & rx_ready & (r_to_read != 7'd0) & ~reset;
                pkt_eop  = w_last;
            end
            S_DONE: pkt_done = 1'b1;
            default: ;
        endcase
    end

    // Read-valid pipeline, length capture and byte counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_len       <= '0;
            r_remaining <= '0;
            r_to_read   <= '0;
        end else begin
            r_valid <= read_enb;
            case (r_state)
                S_HDR: begin
                    r_len       <= data_out[7:2];
                    r_remaining <= w_len_p1;
                    r_to_read   <= w_len_p1;
                end
                S_BODY: begin
                    if (r_valid)  r_remaining <= r_remaining - 7'd1;
                    if (read_enb) r_to_read   <= r_to_read - 7'd1;
                end
                default: ;
            endcase
        end
    end

    // Stall timeout counter: runs only while data waits and the destination refuses it
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   r_to_cnt <= '0;
        else if (read_enb | empty)   r_to_cnt <= '0;
        else if (w_timeout)          r_to_cnt <= '0;
        else if (w_stall)            r_to_cnt <= r_to_cnt + TO_W'(1);
    end

`ifdef ROUTER_OUT_PARITY_CHECK_EN
    logic [7:0] r_acc;
    logic       r_par_err;

    // Parity accumulator seeded by the header; the final byte is compared, not folded in
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_par_err <= 1'b0;
        end else if (r_state == S_HDR) begin
            r_acc     <= data_out;
            r_par_err <= 1'b0;
        end else if ((r_state == S_BODY) && r_valid) begin
            if (r_remaining == 7'd1) r_par_err <= (data_out != r_acc);
            else                     r_acc     <= r_acc ^ data_out;
        end
    end

    assign parity_err = (r_state == S_DONE) & r_par_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_out_pkt_reader.sv
// tb_router_out_pkt_reader: scoreboard bench with a behavioural FIFO model.
module tb_router_out_pkt_reader;

`ifdef ROUTER_OUT_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        int         cyc;
    } beat_t;

    typedef struct {
        logic       perr;
        logic [5:0] len;
        int         cyc;
    } done_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       empty;
    logic [7:0] data_out = 8'h00;
    logic       rx_ready;
    logic       read_enb;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_sop;
    logic       pkt_eop;
    logic [5:0] pkt_len;
    logic       pkt_done;
    logic       parity_err;
    logic       soft_reset_req;
    logic       busy;

    logic [7:0]  mem [0:255];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;

    beat_t exp_q[$];
    beat_t obs_q[$];
    done_t done_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rd_n = 0;
    int srr_n = 0;
    int bad_re = 0;
    int stray = 0;

    router_out_pkt_reader #(.TIMEOUT(30), .TO_W(5)) dut (
        .clk(clk), .reset(reset), .empty(empty), .data_out(data_out),
        .rx_ready(rx_ready), .read_enb(read_enb), .pkt_data(pkt_data),
        .pkt_valid(pkt_valid), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
        .pkt_len(pkt_len), .pkt_done(pkt_done), .parity_err(parity_err),
        .soft_reset_req(soft_reset_req), .busy(busy)
    );

    always #5 clk = ~clk;

    assign empty = (wr_ptr == rd_ptr);

    // FIFO read port: one-cycle read latency
    always @(posedge clk) begin
        if (read_enb && !empty) begin
            data_out <= mem[rd_ptr[7:0]];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    // Monitor: records beats, done pulses and protocol events on the falling edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (pkt_valid) obs_q.push_back('{d: pkt_data, sop: pkt_sop, eop: pkt_eop, cyc: cyc});
        if (pkt_done)  done_q.push_back('{perr: parity_err, len: pkt_len, cyc: cyc});
        if (soft_reset_req) srr_n = srr_n + 1;
        if (read_enb) rd_n = rd_n + 1;
        if (read_enb && empty) bad_re = bad_re + 1;
        if (!pkt_valid && (pkt_sop || pkt_eop)) stray = stray + 1;
        if (parity_err && !pkt_done) stray = stray + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, need finish");
        $fatal(1);
    end

    task automatic put_byte(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Write a full packet into the FIFO and queue its expected beats
    task automatic push_pkt(input logic [5:0] len, input logic [1:0] addr,
                            input bit corrupt, output bit perr_exp);
        logic [7:0] b;
        logic [7:0] p;
        b = {len, addr};
        p = b;
        put_byte(b);
        exp_q.push_back('{d: b, sop: 1'b1, eop: 1'b0, cyc: 0});
        for (int i = 0; i < int'(len); i++) begin
            b = 8'($urandom_range(0, 255));
            p = p ^ b;
            put_byte(b);
            exp_q.push_back('{d: b, sop: 1'b0, eop: 1'b0, cyc: 0});
        end
        if (corrupt) p = p ^ 8'h01;
        put_byte(p);
        exp_q.push_back('{d: p, sop: 1'b0, eop: 1'b1, cyc: 0});
        perr_exp = corrupt & PCHK;
    endtask

    task automatic wait_beats(input int nb, input int nd, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (obs_q.size() >= nb && done_q.size() >= nd) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
        done_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if ({read_enb, pkt_valid, pkt_sop, pkt_eop, pkt_done, parity_err, soft_reset_req, busy} !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: got re=%b v=%b sop=%b eop=%b done=%b perr=%b srr=%b busy=%b, need all 0",
                     read_enb, pkt_valid, pkt_sop, pkt_eop, pkt_done, parity_err, soft_reset_req, busy);
        end
        tests++;
        if (pkt_len !== 6'd0) begin
            fails++;
            $display("FAIL reset_len: got %0d, need 0", pkt_len);
        end
        reset = 1'b0;
        @(negedge clk); #1;
        tests++;
        if (busy !== 1'b0 || read_enb !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got busy=%b re=%b, need 0 0", busy, read_enb);
        end
    endtask

    task automatic test_packet(input string name, input logic [5:0] len,
                               input logic [1:0] addr, input bit corrupt);
        bit    ok;
        bit    pe;
        beat_t e;
        beat_t o;
        done_t d;
        int    nb;
        int    first_c;
        int    last_c;
        clear_queues();
        rx_ready = 1'b1;
        @(negedge clk); #1;
        push_pkt(len, addr, corrupt, pe);
        nb = exp_q.size();
        wait_beats(nb, 1, 200, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s_timeout: got beats=%0d done=%0d, need %0d and 1", name, obs_q.size(), done_q.size(), nb);
        end
        tests++;
        if (obs_q.size() != nb) begin
            fails++;
            $display("FAIL %s_count: got %0d beats, need %0d", name, obs_q.size(), nb);
        end
        first_c = 0;
        last_c  = 0;
        if (obs_q.size() >= 2) begin
            first_c = obs_q[0].cyc;
            last_c  = obs_q[obs_q.size() - 1].cyc;
            tests++;
            if (last_c - first_c != nb) begin
                fails++;
                $display("FAIL %s_span: got %0d cycles first-to-last, need %0d", name, last_c - first_c, nb);
            end
            tests++;
            if (obs_q[1].cyc - first_c != 2) begin
                fails++;
                $display("FAIL %s_bubble: got gap %0d after header, need 2", name, obs_q[1].cyc - first_c);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o.d !== e.d || o.sop !== e.sop || o.eop !== e.eop) begin
                fails++;
                $display("FAIL %s_beat: got d=%02h sop=%b eop=%b, need d=%02h sop=%b eop=%b",
                         name, o.d, o.sop, o.eop, e.d, e.sop, e.eop);
            end
        end
        tests++;
        if (done_q.size() != 1) begin
            fails++;
            $display("FAIL %s_done_count: got %0d, need 1", name, done_q.size());
        end else begin
            d = done_q[0];
            tests++;
            if (d.perr !== pe) begin
                fails++;
                $display("FAIL %s_perr: got %b, need %b", name, d.perr, pe);
            end
            tests++;
            if (d.len !== len) begin
                fails++;
                $display("FAIL %s_len: got %0d, need %0d", name, d.len, len);
            end
            tests++;
            if (d.cyc != last_c + 1) begin
                fails++;
                $display("FAIL %s_done_cycle: got %0d, need %0d", name, d.cyc, last_c + 1);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rx_stall();
        bit    ok;
        bit    pe;
        beat_t e;
        beat_t o;
        int    rd0;
        int    srr0;
        clear_queues();
        rx_ready = 1'b1;
        @(negedge clk); #1;
        push_pkt(6'd10, 2'b11, 1'b0, pe);
        wait_beats(5, 0, 100, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL stall_start: got %0d beats, need 5", obs_q.size());
        end
        @(posedge clk); #1;
        rx_ready = 1'b0;
        rd0  = rd_n;
        srr0 = srr_n;
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (rd_n != rd0) begin
            fails++;
            $display("FAIL stall_reads: got %0d reads while stalled, need 0", rd_n - rd0);
        end
        tests++;
        if (obs_q.size() != 6) begin
            fails++;
            $display("FAIL stall_inflight: got %0d beats, need 6", obs_q.size());
        end
        tests++;
        if (srr_n != srr0) begin
            fails++;
            $display("FAIL stall_srr: got %0d pulses, need 0", srr_n - srr0);
        end
        rx_ready = 1'b1;
        wait_beats(12, 1, 100, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL stall_finish: got beats=%0d done=%0d, need 12 and 1", obs_q.size(), done_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o.d !== e.d || o.sop !== e.sop || o.eop !== e.eop) begin
                fails++;
                $display("FAIL stall_beat: got d=%02h sop=%b eop=%b, need d=%02h sop=%b eop=%b",
                         o.d, o.sop, o.eop, e.d, e.sop, e.eop);
            end
        end
        tests++;
        if (done_q.size() != 1 || done_q[0].perr !== 1'b0) begin
            fails++;
            $display("FAIL stall_done: got count=%0d, need 1 with parity ok", done_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        bit   ok;
        bit   pe;
        int   hit;
        int   nsrr;
        int   rd0;
        int   done0;
        logic busy_next;
        clear_queues();
        rx_ready = 1'b1;
        @(negedge clk); #1;
        push_pkt(6'd10, 2'b00, 1'b0, pe);
        wait_beats(3, 0, 100, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL timeout_start: got %0d beats, need 3", obs_q.size());
        end
        @(posedge clk); #1;
        rx_ready  = 1'b0;
        rd0       = rd_n;
        done0     = done_q.size();
        hit       = -1;
        nsrr      = 0;
        busy_next = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk); #1;
            if (soft_reset_req) begin
                nsrr++;
                if (hit < 0) hit = i;
            end
            if (hit > 0 && i == hit + 1) busy_next = busy;
        end
        tests++;
        if (hit != 30) begin
            fails++;
            $display("FAIL timeout_cycle: got pulse at stalled cycle %0d, need 30", hit);
        end
        tests++;
        if (nsrr != 1) begin
            fails++;
            $display("FAIL timeout_once: got %0d pulses, need 1", nsrr);
        end
        tests++;
        if (busy_next !== 1'b0) begin
            fails++;
            $display("FAIL timeout_busy: got %b after pulse, need 0", busy_next);
        end
        tests++;
        if (done_q.size() != done0 || rd_n != rd0) begin
            fails++;
            $display("FAIL timeout_quiet: got done=%0d reads=%0d, need 0 0", done_q.size() - done0, rd_n - rd0);
        end
        wr_ptr = rd_ptr;
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit         ok;
        bit         pe;
        logic [7:0] nb;
        beat_t      o;
        clear_queues();
        rx_ready = 1'b1;
        @(negedge clk); #1;
        push_pkt(6'd8, 2'b10, 1'b0, pe);
        wait_beats(4, 0, 100, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rstmid_start: got %0d beats, need 4", obs_q.size());
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({read_enb, pkt_valid, pkt_sop, pkt_eop, pkt_done, parity_err, soft_reset_req, busy} !== 8'h00
            || pkt_len !== 6'd0) begin
            fails++;
            $display("FAIL rstmid_outputs: got re=%b v=%b sop=%b eop=%b done=%b perr=%b srr=%b busy=%b len=%0d, need all 0",
                     read_enb, pkt_valid, pkt_sop, pkt_eop, pkt_done, parity_err, soft_reset_req, busy, pkt_len);
        end
        @(posedge clk); #1;
        nb = mem[rd_ptr[7:0]];
        @(negedge clk); #1;
        obs_q.delete();
        reset = 1'b0;
        wait_beats(1, 0, 20, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rstmid_resume: got 0 beats, need 1");
        end else begin
            o = obs_q[0];
            tests++;
            if (o.d !== nb || o.sop !== 1'b1 || o.eop !== 1'b0) begin
                fails++;
                $display("FAIL rstmid_header: got d=%02h sop=%b eop=%b, need d=%02h sop=1 eop=0", o.d, o.sop, o.eop, nb);
            end
            @(negedge clk); #1;
            tests++;
            if (pkt_len !== nb[7:2]) begin
                fails++;
                $display("FAIL rstmid_len: got %0d, need %0d", pkt_len, nb[7:2]);
            end
        end
        rx_ready = 1'b0;
        @(negedge clk); #1;
        reset = 1'b1;
        wr_ptr = rd_ptr;
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_invariants();
        tests++;
        if (bad_re != 0) begin
            fails++;
            $display("FAIL read_while_empty: got %0d cycles, need 0", bad_re);
        end
        tests++;
        if (stray != 0) begin
            fails++;
            $display("FAIL stray_marks: got %0d cycles, need 0", stray);
        end
    endtask

    initial begin
        reset = 1'b1;
        rx_ready = 1'b0;
        test_reset();
        test_packet("good", 6'd14, 2'b01, 1'b0);
        test_packet("bad", 6'd14, 2'b01, 1'b1);
        test_packet("zero", 6'd0, 2'b10, 1'b0);
        test_rx_stall();
        test_timeout();
        test_reset_mid();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/router_out_pkt_reader.md
Name: router_out_pkt_reader

Overview:
- Drain-side controller for one router output FIFO.
- Pops header, payload and parity bytes from the FIFO read port and streams them to the destination with start/end-of-packet marks.
- Recomputes parity and flags mismatches.
- Requests a FIFO soft reset when the destination stalls a pending packet too long.
- One instance sits between each output FIFO and its destination port.

Parameters:
- TIMEOUT, 30, consecutive stalled cycles (FIFO non-empty, rx_ready low) before soft_reset_req fires.
- TO_W, 5, width of the timeout counter; must hold TIMEOUT-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- empty  input  1  FIFO empty flag.
- data_out  input  8  FIFO read data; valid the cycle after read_enb was high with empty low.
- rx_ready  input  1  destination can accept a byte.
- read_enb  output  1  FIFO pop request.
- pkt_data  output  8  byte to destination; combinational pass of data_out.
- pkt_valid  output  1  pkt_data valid this cycle.
- pkt_sop  output  1  header byte on pkt_data.
- pkt_eop  output  1  parity byte on pkt_data.
- pkt_len  output  6  payload length captured from header[7:2]; held until the next header.
- pkt_done  output  1  one-cycle pulse the cycle after eop.
- parity_err  output  1  one-cycle pulse with pkt_done when parity mismatches.
- soft_reset_req  output  1  one-cycle timeout pulse.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (asynchronous) clears all registers. Outputs at reset: read_enb 0, pkt_valid 0, pkt_sop 0, pkt_eop 0, pkt_done 0, parity_err 0, soft_reset_req 0, pkt_len 0. State returns to IDLE.
- Packet format: header {len[5:0], addr[1:0]}, then len payload bytes, then one parity byte. Expected parity is the XOR of the header and all payload bytes. len=0 is legal: a 2-byte packet.
- Read latency: a read issued in cycle N returns data in cycle N+1. pkt_valid is the registered version of (read_enb & ~empty).
- read_enb is combinational from state, empty, rx_ready and remaining count. It is never high while empty is high.
- State IDLE:
  - read_enb = ~empty & rx_ready.
  - On a read, go to HDR.
- State HDR (header arriving):
  - pkt_valid=1, pkt_sop=1.
  - Capture pkt_len and seed acc = data_out.
  - remaining = len+1.
  - read_enb=0 this cycle (one-bubble stall so the length is known before further reads).
  - Go to BODY.
- State BODY:
  - read_enb = ~empty & rx_ready & (issued < len+1).
  - Back-to-back reads are allowed, one byte per cycle at steady state.
  - Each returned byte decrements remaining.
  - A returned byte with remaining > 1 is payload: acc ^= byte.
  - The returned byte with remaining == 1 is parity: pkt_eop=1, compare against acc, go to DONE.
- State DONE:
  - pkt_done=1; parity_err=1 if the comparison failed.
  - read_enb=0.
  - Go to IDLE. A new header can be read the following cycle.
- Timeout counter:
  - Counts cycles where ~empty & ~rx_ready in IDLE or BODY.
  - Clears on any read or when empty is high.
  - On reaching TIMEOUT: pulse soft_reset_req for one cycle, clear the counter, go to IDLE, no pkt_done. The packet is abandoned.
  - Later bytes are whatever the flushed FIFO holds; the next byte read is treated as a header.
- rx_ready drop mid-packet: reads pause, no byte is lost, the in-flight read still returns and is presented. The destination must accept the in-flight byte one cycle after dropping rx_ready.
- empty mid-packet (packet still being written): reads pause; the timeout counter does not run.
- reset mid-packet: immediate return to IDLE, accumulator and counters cleared.

Optional Feature:
- Macro ROUTER_OUT_PARITY_CHECK_EN.
- Defined: parity accumulator and comparison as above.
- Undefined: no accumulator logic; parity_err is tied 0. The parity byte is still consumed and marked with pkt_eop, and pkt_done still pulses.

Test Plan:
1. Write header 8'h39 (len 14, addr 01), 14 payload bytes, correct XOR parity; rx_ready=1 → 16 pkt_valid beats over 17 cycles (one bubble after the header), sop on 8'h39, eop on the parity byte, pkt_len=14, pkt_done=1, parity_err=0.
2. Same packet with parity XOR 8'h01 (wrong) → identical stream, pkt_done=1 and parity_err=1 in the same cycle (0 with the macro undefined).
3. Header 8'h02 (len 0) then parity 8'h02 → 2 beats, sop then eop, pkt_done, parity_err=0.
4. Drop rx_ready for 5 cycles after payload byte 4 → in-flight byte 5 presented, no reads for 5 cycles, no soft_reset_req, remaining bytes delivered intact.
5. FIFO non-empty, rx_ready held low 30 cycles → soft_reset_req pulses exactly once at the 30th stalled cycle, busy=0 the next cycle, no pkt_done.
6. Assert reset for one cycle mid-payload → all outputs 0 immediately; after release, the next FIFO byte is read as a header with sop=1.
